// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file write port between ALU (A) and load (B) results.
// Optional: define REGFILE_ZERO_GUARD_EN to accept and silently drop writes to register 0.

module regfile_wb_fifo #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 pop_i,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [ADDR_W-1:0]    head_addr_o,
  output logic [DATA_W-1:0]    head_data_o,
  output logic [2**ADDR_W-1:0] pend_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  rptr_q, wptr_q;
  logic [CNT_W-1:0]  cnt_q;

  // Storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wptr_q] <= addr_i;
      data_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign head_addr_o = addr_q[rptr_q];
  assign head_data_o = data_q[rptr_q];

  // Walk the live window starting at the read pointer.
  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < cnt_q) pend_o[addr_q[rptr_q + PTR_W'(i)]] = 1'b1;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] pend_mask
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic {GNT_A, GNT_B} grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                a_push, b_push, gnt_a, gnt_b;
  logic                a_empty, a_full, b_empty, b_full;
  logic [ADDR_W-1:0]   a_head_addr, b_head_addr;
  logic [DATA_W-1:0]   a_head_data, b_head_data;
  logic [NREG-1:0]     a_pend, b_pend;

  assign a_ready = !a_full;
  assign b_ready = !b_full;

`ifdef REGFILE_ZERO_GUARD_EN
  // Register 0 writes still handshake but never reach a FIFO.
  assign a_push = a_valid && a_ready && (a_addr != '0);
  assign b_push = b_valid && b_ready && (b_addr != '0);
`else
  assign a_push = a_valid && a_ready;
  assign b_push = b_valid && b_ready;
`endif

  regfile_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push_i(a_push), .addr_i(a_addr), .data_i(a_data),
    .pop_i(gnt_a), .empty_o(a_empty), .full_o(a_full),
    .head_addr_o(a_head_addr), .head_data_o(a_head_data), .pend_o(a_pend)
  );

  regfile_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push_i(b_push), .addr_i(b_addr), .data_i(b_data),
    .pop_i(gnt_b), .empty_o(b_empty), .full_o(b_full),
    .head_addr_o(b_head_addr), .head_data_o(b_head_data), .pend_o(b_pend)
  );

  always_comb begin
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    // On a tie, the requester that lost last time wins.
    if (!a_empty && (b_empty || last_grant_q == GNT_B)) begin
      gnt_a        = 1'b1;
      last_grant_d = GNT_A;
      wr_en_d      = 1'b1;
      wr_addr_d    = a_head_addr;
      wr_data_d    = a_head_data;
    end else if (!b_empty) begin
      gnt_b        = 1'b1;
      last_grant_d = GNT_B;
      wr_en_d      = 1'b1;
      wr_addr_d    = b_head_addr;
      wr_data_d    = b_head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_B;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  always_comb begin
    pend_mask = a_pend | b_pend;
    if (wr_en_q) pend_mask[wr_addr_q] = 1'b1;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
// Honours REGFILE_ZERO_GUARD_EN the same way as the design build.

module tb_regfile_wb_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int NREG   = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } log_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              a_ready, b_ready, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   pend_mask;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;
  int cyc  = 0;

  // Reference model state: one queue per requester plus the expected output stage.
  wr_t               qa[$], qb[$];
  bit                lastWasA;
  logic              expWrEn;
  logic [ADDR_W-1:0] expWrAddr;
  logic [DATA_W-1:0] expWrData;
  bit                accA, accB;

  // What the register file actually saw at its mid-cycle write strobe.
  log_t              wrLog[$];
  logic [DATA_W-1:0] rfObs [NREG];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      wrLog.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
      rfObs[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit dropped(input logic [ADDR_W-1:0] addr);
`ifdef REGFILE_ZERO_GUARD_EN
    return addr == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [NREG-1:0] modelPend();
    logic [NREG-1:0] m = '0;
    foreach (qa[i]) m[qa[i].addr] = 1'b1;
    foreach (qb[i]) m[qb[i].addr] = 1'b1;
    if (expWrEn) m[expWrAddr] = 1'b1;
    return m;
  endfunction

  // One clock edge of the specified behaviour, using the pre-edge queue contents.
  task automatic modelEdge();
    bit  gA, gB;
    wr_t e;
    accA = a_valid && (qa.size() < DEPTH);
    accB = b_valid && (qb.size() < DEPTH);
    gA = (qa.size() > 0) && ((qb.size() == 0) || !lastWasA);
    gB = !gA && (qb.size() > 0);
    expWrEn = gA || gB;
    if (gA) begin
      e = qa.pop_front();
      expWrAddr = e.addr; expWrData = e.data; lastWasA = 1'b1;
    end else if (gB) begin
      e = qb.pop_front();
      expWrAddr = e.addr; expWrData = e.data; lastWasA = 1'b0;
    end
    if (accA && !dropped(a_addr)) qa.push_back('{addr: a_addr, data: a_data});
    if (accB && !dropped(b_addr)) qb.push_back('{addr: b_addr, data: b_data});
  endtask

  task automatic checkOutput();
    check("wr_en", DATA_W'(wr_en), DATA_W'(expWrEn));
    check("wr_addr", DATA_W'(wr_addr), DATA_W'(expWrAddr));
    check("wr_data", wr_data, expWrData);
    check("pend_mask", DATA_W'(pend_mask), DATA_W'(modelPend()));
    check("a_ready", DATA_W'(a_ready), DATA_W'(qa.size() < DEPTH));
    check("b_ready", DATA_W'(b_ready), DATA_W'(qb.size() < DEPTH));
  endtask

  task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                               input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic doReset();
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    #1;
    qa.delete(); qb.delete();
    lastWasA = 1'b0; expWrEn = 1'b0; expWrAddr = '0; expWrData = '0;
    check("rst wr_en", DATA_W'(wr_en), '0);
    check("rst wr_addr", DATA_W'(wr_addr), '0);
    check("rst wr_data", wr_data, '0);
    check("rst pend_mask", DATA_W'(pend_mask), '0);
    check("rst a_ready", DATA_W'(a_ready), 64'd1);
    check("rst b_ready", DATA_W'(b_ready), 64'd1);
    @(posedge clk); #1;
    check("rst hold wr_en", DATA_W'(wr_en), '0);
    @(negedge clk);
    rst = 1'b0;
    wrLog.delete();
  endtask

  initial begin
    int          nA, nB, aWrites;
    logic [63:0] expOrder [8];

    // Single write from A, B idle.
    doReset();
    applyStimulus(1'b1, 5'd3, 64'hDEADBEEF_00000001, 1'b0, '0, '0);
    check("single accept wr_en", DATA_W'(wr_en), '0);
    check("single pend3 queued", DATA_W'(pend_mask[3]), 64'd1);
    idle(1);
    check("single wr_en", DATA_W'(wr_en), 64'd1);
    check("single wr_addr", DATA_W'(wr_addr), 64'd3);
    check("single wr_data", wr_data, 64'hDEADBEEF_00000001);
    idle(1);
    check("single wr_en drop", DATA_W'(wr_en), '0);
    check("single pend3 clear", DATA_W'(pend_mask[3]), '0);
    idle(1);

    // Contention: both stream 4 writes with valids held until accepted.
    doReset();
    nA = 0; nB = 0;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(nA < 4, ADDR_W'(1 + nA), 64'hA0 + 64'(nA), nB < 4, ADDR_W'(5 + nB), 64'hB0 + 64'(nB));
      if (accA) nA++;
      if (accB) nB++;
    end
    expOrder = '{1, 5, 2, 6, 3, 7, 4, 8};
    check("contention count", 64'(wrLog.size()), 64'd8);
    for (int i = 0; i < 8 && i < wrLog.size(); i++) begin
      check("contention order", DATA_W'(wrLog[i].addr), expOrder[i]);
      check("contention no gap", 64'(wrLog[i].cyc - wrLog[0].cyc), 64'(i));
    end

    // Backpressure: B saturates, A sends 4 with valid held.
    doReset();
    nA = 0; nB = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(nA < 4, ADDR_W'(20 + nA), 64'hC0 + 64'(nA), nB < 8, ADDR_W'(10 + nB % 4), 64'hD0 + 64'(nB));
      if (accA) nA++;
      if (accB) nB++;
    end
    aWrites = 0;
    foreach (wrLog[i]) if (wrLog[i].addr >= 20 && wrLog[i].addr < 24) begin
      check("bp A data in order", wrLog[i].data, 64'hC0 + 64'(aWrites));
      aWrites++;
    end
    check("bp A write count", 64'(aWrites), 64'd4);
    check("bp total writes", 64'(wrLog.size()), 64'd12);

    // Same address from both requesters in one cycle.
    doReset();
    applyStimulus(1'b1, 5'd9, 64'h11, 1'b1, 5'd9, 64'h22);
    idle(4);
    check("same addr count", 64'(wrLog.size()), 64'd2);
    if (wrLog.size() == 2) begin
      check("same addr first", wrLog[0].data, 64'h11);
      check("same addr second", wrLog[1].data, 64'h22);
    end
    check("same addr file", rfObs[9], 64'h22);

    // Reset with entries queued in both FIFOs.
    doReset();
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b1, ADDR_W'(12 + c), 64'(c), 1'b1, ADDR_W'(16 + c), 64'(c + 8));
    doReset();
    idle(4);
    check("post reset no write", 64'(wrLog.size()), '0);
    applyStimulus(1'b1, 5'd2, 64'h2222, 1'b0, '0, '0);
    idle(3);
    check("post reset A write", 64'(wrLog.size()), 64'd1);
    if (wrLog.size() > 0) check("post reset addr", DATA_W'(wrLog[0].addr), 64'd2);

    // Register 0 write.
    doReset();
    check("zero a_ready", DATA_W'(a_ready), 64'd1);
    applyStimulus(1'b1, 5'd0, 64'hFF, 1'b0, '0, '0);
    idle(3);
`ifdef REGFILE_ZERO_GUARD_EN
    check("zero dropped", 64'(wrLog.size()), '0);
`else
    check("zero written", 64'(wrLog.size()), 64'd1);
    if (wrLog.size() > 0) check("zero addr", DATA_W'(wrLog[0].addr), '0);
`endif

    // Random traffic against the model.
    doReset();
    for (int c = 0; c < 400; c++)
      applyStimulus($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, NREG - 1)), {$urandom, $urandom},
                    $urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, NREG - 1)), {$urandom, $urandom});
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
